// File: rtl/igbt_gate_seq.sv
// Half-bridge IGBT gate sequencer: non-overlapping gate drives with dead time, minimum
// pulse width and desaturation-fault lockout, all timed by external timebase strobes.
module igbt_gate_seq #(
   parameter int unsigned DEADTIME_US  = 2,
   parameter int unsigned MIN_PULSE_US = 5,
   parameter int unsigned LOCKOUT_MS   = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1us,
   input  logic       tick_1ms,
   input  logic       cmd_en,
   input  logic       cmd_hi,
   input  logic       fault_in,
   input  logic       fault_clr,
   output logic       gate_hi,
   output logic       gate_lo,
   output logic       fault_lock,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StDtToHi = 3'd1,
      StHiOn   = 3'd2,
      StDtToLo = 3'd3,
      StLoOn   = 3'd4,
      StFault  = 3'd5
   } state_e;

   localparam logic [9:0] DtLast  = 10'(DEADTIME_US - 1);
   localparam logic [9:0] MinCnt  = 10'(MIN_PULSE_US);
   localparam logic [9:0] LockCnt = 10'(LOCKOUT_MS);
   localparam logic [9:0] CntMax  = 10'h3ff;

   state_e     state_q, state_d;
   logic [9:0] cnt_q, cnt_d;
   logic       cnt_tick;
   logic       cnt_clr;

   always_comb begin
      state_d  = state_q;
      cnt_tick = 1'b0;
      cnt_clr  = 1'b0;
      if (fault_in && state_q != StFault) begin
         state_d = StFault;
      end else begin
         case (state_q)
            StIdle: begin
               if (cmd_en) state_d = cmd_hi ? StDtToHi : StDtToLo;
            end
            StDtToHi: begin
               cnt_tick = tick_1us;
               if (!cmd_en)                          state_d = StIdle;
               else if (!cmd_hi)                     state_d = StDtToLo;
               else if (tick_1us && cnt_q >= DtLast) state_d = StHiOn;
            end
            StDtToLo: begin
               cnt_tick = tick_1us;
               if (!cmd_en)                          state_d = StIdle;
               else if (cmd_hi)                      state_d = StDtToHi;
               else if (tick_1us && cnt_q >= DtLast) state_d = StLoOn;
            end
            StHiOn: begin
               cnt_tick = tick_1us;
               if (cnt_q >= MinCnt) begin
                  if (!cmd_en)     state_d = StIdle;
                  else if (!cmd_hi) state_d = StDtToLo;
               end
            end
            StLoOn: begin
               cnt_tick = tick_1us;
               if (cnt_q >= MinCnt) begin
                  if (!cmd_en)    state_d = StIdle;
                  else if (cmd_hi) state_d = StDtToHi;
               end
            end
            StFault: begin
               cnt_tick = tick_1ms;
               // A fault re-asserting during lockout restarts the lockout window.
               if (fault_in)                            cnt_clr = 1'b1;
               else if (cnt_q >= LockCnt && fault_clr) state_d = StIdle;
            end
            default: state_d = StFault;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q || cnt_clr)   cnt_d = '0;
      else if (cnt_tick && cnt_q != CntMax) cnt_d = cnt_q + 10'd1;
   end

   // Gate outputs are decoded from the next state so they move on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         gate_hi    <= 1'b0;
         gate_lo    <= 1'b0;
         fault_lock <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gate_hi    <= (state_d == StHiOn);
         gate_lo    <= (state_d == StLoOn);
         fault_lock <= (state_d == StFault);
      end
   end

   assign state_o = state_q;

   a_no_shoot_through : assert property (@(posedge clk) !(gate_hi && gate_lo));

endmodule

// File: tb/tb_igbt_gate_seq.sv
// Bench for igbt_gate_seq: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a mode/side/elapsed-ticks reference model.
module tb_igbt_gate_seq;

   localparam int DT = 2;
   localparam int MP = 5;
   localparam int LK = 100;

   localparam int MIdle  = 0;
   localparam int MDead  = 1;
   localparam int MOn    = 2;
   localparam int MFault = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1us = 1'b0, tick_1ms = 1'b0;
   logic       cmd_en = 1'b0, cmd_hi = 1'b0;
   logic       fault_in = 1'b0, fault_clr = 1'b0;
   logic       gate_hi, gate_lo, fault_lock;
   logic [2:0] state_o;

   int total = 0;
   int bad = 0;
   int hi_cnt = 0;
   int us_ph = 0, ms_ph = 0, ms_per = 0;
   bit rand_mode = 1'b0;

   // Reference model: what the leg is doing, which side, and how many ticks have elapsed.
   int m_mode = MIdle;
   bit m_hi = 1'b0;
   int m_ticks = 0;
   int nm, nt;
   bit nh;

   igbt_gate_seq #(
      .DEADTIME_US (DT),
      .MIN_PULSE_US(MP),
      .LOCKOUT_MS  (LK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_1us  (tick_1us),
      .tick_1ms  (tick_1ms),
      .cmd_en    (cmd_en),
      .cmd_hi    (cmd_hi),
      .fault_in  (fault_in),
      .fault_clr (fault_clr),
      .gate_hi   (gate_hi),
      .gate_lo   (gate_lo),
      .fault_lock(fault_lock),
      .state_o   (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode  <= MIdle;
         m_hi    <= 1'b0;
         m_ticks <= 0;
      end else begin
         nm = m_mode;
         nh = m_hi;
         nt = m_ticks;
         if (fault_in && m_mode != MFault) begin
            nm = MFault;
            nt = 0;
         end else if (m_mode == MFault) begin
            if (fault_in) nt = 0;
            else if (m_ticks >= LK && fault_clr) begin
               nm = MIdle;
               nt = 0;
            end else nt = m_ticks + int'(tick_1ms);
         end else if (m_mode == MIdle) begin
            if (cmd_en) begin
               nm = MDead;
               nh = cmd_hi;
               nt = 0;
            end
         end else if (m_mode == MDead) begin
            if (!cmd_en) begin
               nm = MIdle;
               nt = 0;
            end else if (cmd_hi != m_hi) begin
               nh = cmd_hi;
               nt = 0;
            end else if (tick_1us && m_ticks + 1 >= DT) begin
               nm = MOn;
               nt = 0;
            end else nt = m_ticks + int'(tick_1us);
         end else begin
            if (m_ticks >= MP && !cmd_en) begin
               nm = MIdle;
               nt = 0;
            end else if (m_ticks >= MP && cmd_hi != m_hi) begin
               nm = MDead;
               nh = cmd_hi;
               nt = 0;
            end else nt = m_ticks + int'(tick_1us);
         end
         if (nt > 1023) nt = 1023;
         m_mode  <= nm;
         m_hi    <= nh;
         m_ticks <= nt;
      end
   end

   function automatic int exp_code(input int mode, input bit hi);
      if (mode == MIdle) return 0;
      if (mode == MFault) return 5;
      if (mode == MDead) return hi ? 1 : 3;
      return hi ? 2 : 4;
   endfunction

   always @(negedge clk) begin
      check("model_state", 32'(state_o), 32'(exp_code(m_mode, m_hi)));
      check("model_gate_hi", 32'(gate_hi), 32'(m_mode == MOn && m_hi));
      check("model_gate_lo", 32'(gate_lo), 32'(m_mode == MOn && !m_hi));
      check("model_fault_lock", 32'(fault_lock), 32'(m_mode == MFault));
      check("no_overlap", 32'(gate_hi & gate_lo), 32'd0);
      if (gate_hi === 1'b1) hi_cnt++;
   end

   task automatic drive();
      if (rand_mode) begin
         tick_1us  = ($urandom_range(3) == 0);
         tick_1ms  = ($urandom_range(2) == 0);
         if ($urandom_range(199) == 0) cmd_en = ~cmd_en;
         if ($urandom_range(59) == 0) cmd_hi = ~cmd_hi;
         fault_in  = ($urandom_range(699) == 0);
         fault_clr = ($urandom_range(5) == 0);
         if (!rst_n) rst_n = 1'b1;
         else if ($urandom_range(6999) == 0) rst_n = 1'b0;
      end else begin
         us_ph++;
         ms_ph++;
         tick_1us = (us_ph % 40 == 0);
         tick_1ms = (ms_per != 0) && (ms_ph % ms_per == 0);
      end
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         drive();
      end
   endtask

   // Returns with a 1 us tick pending for the next edge.
   task automatic wait_us();
      for (int i = 0; i < 200; i++) begin
         cyc(1);
         if (tick_1us) return;
      end
      check("wait_us_timeout", 32'd0, 32'd1);
   endtask

   // Lets n ms ticks be sampled by the DUT.
   task automatic wait_ms(input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 50; i++) begin
            cyc(1);
            if (tick_1ms) break;
         end
         if (!tick_1ms) check("wait_ms_timeout", 32'd0, 32'd1);
         cyc(1);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin
      int hi_before;
      cmd_en = 1'b1;
      cmd_hi = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_gates", 32'({gate_hi, gate_lo, fault_lock}), 32'd0);
      rst_n = 1'b1;
      us_ph = 0;

      // Power-up into high side.
      cyc(1);
      check("idle_to_dthi", 32'(state_o), 32'd1);
      wait_us();
      cyc(1);
      check("dthi_after_tick1", 32'(state_o), 32'd1);
      wait_us();
      check("gate_hi_before_tick2_edge", 32'(gate_hi), 32'd0);
      cyc(1);
      check("gate_hi_on", 32'({gate_hi, gate_lo}), 32'b10);
      check("hi_on_state", 32'(state_o), 32'd2);

      // Command flip inside minimum pulse is held off.
      wait_us();
      wait_us();
      cyc(1);
      cmd_hi = 1'b0;
      repeat (3) wait_us();
      check("hi_held_at_tick5", 32'(gate_hi), 32'd1);
      cyc(1);
      check("hi_held_min_done", 32'({gate_hi, state_o}), 32'({1'b1, 3'd2}));
      cyc(1);
      check("to_dtlo", 32'({gate_hi, gate_lo, state_o}), 32'({2'b00, 3'd3}));
      wait_us();
      wait_us();
      check("lo_off_at_dt_tick2", 32'(gate_lo), 32'd0);
      cyc(1);
      check("lo_on", 32'({gate_hi, gate_lo, state_o}), 32'({2'b01, 3'd4}));

      // Fault from LO_ON.
      repeat (5) wait_us();
      cyc(2);
      cmd_en = 1'b0;
      fault_in = 1'b1;
      cyc(1);
      fault_in = 1'b0;
      check("fault_entry", 32'({gate_lo, fault_lock, state_o}), 32'({2'b01, 3'd5}));
      ms_ph = 0;
      ms_per = 4;

      // Lockout: clears at 50 and 99 ms are ignored, accepted at 100 ms.
      wait_ms(50);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      check("clr_at_50", 32'(state_o), 32'd5);
      wait_ms(49);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      check("clr_at_99", 32'({fault_lock, state_o}), 32'({1'b1, 3'd5}));
      wait_ms(1);
      fault_clr = 1'b1;
      cyc(1);
      fault_clr = 1'b0;
      check("clr_at_100", 32'({fault_lock, state_o}), 32'({1'b0, 3'd0}));
      ms_per = 0;

      // Direction flip during dead time restarts the count.
      hi_before = hi_cnt;
      cmd_en = 1'b1;
      cmd_hi = 1'b1;
      cyc(1);
      check("flip_dthi", 32'(state_o), 32'd1);
      wait_us();
      cyc(1);
      cmd_hi = 1'b0;
      cyc(1);
      check("flip_dtlo", 32'(state_o), 32'd3);
      wait_us();
      cyc(1);
      check("flip_fresh_count", 32'(state_o), 32'd3);
      wait_us();
      cyc(1);
      check("flip_lo_on", 32'({gate_lo, state_o}), 32'({1'b1, 3'd4}));
      check("flip_hi_never", 32'(hi_cnt - hi_before), 32'd0);

      // Asynchronous reset while high side is on.
      cmd_hi = 1'b1;
      for (int i = 0; i < 1000 && gate_hi !== 1'b1; i++) cyc(1);
      check("reached_hi_on", 32'(gate_hi), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_gates", 32'({gate_hi, gate_lo, fault_lock}), 32'd0);
      check("async_rst_state", 32'(state_o), 32'd0);
      cyc(2);
      rst_n = 1'b1;

      // Random run against the model.
      rand_mode = 1'b1;
      cmd_en = 1'b1;
      cyc(20000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
